gray_code_conv_pipe: RTL and testbench

Parametrised, pipelined Gray/binary code converter with valid/ready handshakes on both sides. It converts N-bit words per transfer in either direction (Gray→binary or binary→Gray), selected per word, and sustains one word per clock under backpressure. It sits between a Gray-coded source (encoder, async-FIFO pointer, position sensor) and binary consumers. It is the multi-width, multi-stage successor of the 4-bit combinational Gray-to-binary converter.

---
 rtl/gray_conv_pkg.sv | 25 ++
 rtl/gray_conv_stage.sv | 79 +++++++
 rtl/gray_code_conv_pipe.sv | 111 +++++++++++
 tb/tb_gray_code_conv_pipe.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: shared constants, chunk-size helper and stage payload
// for the pipelined Gray/binary converter.
package gray_conv_pkg;

   localparam int GRAY_CONV_MAX_W = 64;

   localparam logic GRAY_CONV_G2B = 1'b0;
   localparam logic GRAY_CONV_B2G = 1'b1;

   // result bits resolved per stage
   function automatic int gray_conv_ch(input int width, input int stages);
      return (width + stages - 1) / stages;
   endfunction

   typedef struct packed {
      logic [GRAY_CONV_MAX_W-1:0] partial;
      logic [GRAY_CONV_MAX_W-1:0] raw;
      logic                       msb;
      logic                       mode;
      logic                       err;
   } gray_conv_pl_t;

   localparam int GRAY_CONV_PL_W = $bits(gray_conv_pl_t);

endpackage

// File: rtl/gray_conv_stage.sv
// gray_conv_stage: one pipeline slot resolving a CH-bit chunk of the
// MSB-first prefix XOR, with its own valid bit and load/ready logic.
module gray_conv_stage
   import gray_conv_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2,
   parameter int IDX    = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      up_valid,
   input  logic [GRAY_CONV_PL_W-1:0] up_data,
   output logic                      up_ready,
   input  logic                      dn_load,
   output logic                      v_o,
   output logic [GRAY_CONV_PL_W-1:0] pl_o
);

   localparam int CH = gray_conv_ch(WIDTH, STAGES);
   localparam int HI = WIDTH - 1 - IDX * CH;
   localparam int LO = WIDTH - (IDX + 1) * CH;

   gray_conv_pl_t up_pl;
   gray_conv_pl_t res;
   gray_conv_pl_t pl_d, pl_q;
   logic          v_d, v_q;
   logic          load;
   logic          run;

   assign up_pl = up_data;

   // resolve this stage's chunk; binary->Gray finishes in stage 0
   always_comb begin
      res = up_pl;
      run = up_pl.msb;
      if (up_pl.mode == GRAY_CONV_G2B) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i <= HI && i >= LO) begin
               run            = run ^ up_pl.raw[i];
               res.partial[i] = run;
            end
         end
         res.msb = run;
      end else if (IDX == 0) begin
         res.partial = up_pl.raw ^ (up_pl.raw >> 1);
      end
   end

   assign load     = !v_q || dn_load;
   assign up_ready = load;

   // next-state for valid bit and payload
   always_comb begin
      v_d  = v_q;
      pl_d = pl_q;
      if (load) begin
         v_d = up_valid;
         if (up_valid) begin
            pl_d = res;
         end
      end
   end

   // stage register with synchronous clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q  <= 1'b0;
         pl_q <= '0;
      end else begin
         v_q  <= v_d;
         pl_q <= pl_d;
      end
   end

   assign v_o  = v_q;
   assign pl_o = pl_q;

endmodule

// File: rtl/gray_code_conv_pipe.sv
// gray_code_conv_pipe: pipelined Gray<->binary converter, valid/ready.
// GRAY_CONV_STEP_CHECK_EN adds the step_err port and Gray-step checker.
module gray_code_conv_pipe
   import gray_conv_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_mode
`ifdef GRAY_CONV_STEP_CHECK_EN
   ,
   output logic             step_err
`endif
);

   logic [STAGES-1:0]         v;
   logic [STAGES:0]           ld;
   logic [GRAY_CONV_PL_W-1:0] pl [STAGES];
   gray_conv_pl_t             in_pl;
   gray_conv_pl_t             out_pl;
   logic                      in_err;

   // build the stage-0 payload from the raw input word
   always_comb begin
      in_pl              = '0;
      in_pl.raw[WIDTH-1:0] = in_data;
      in_pl.mode         = in_mode;
      in_pl.err          = in_err;
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic                      up_valid_w;
      logic [GRAY_CONV_PL_W-1:0] up_data_w;
      if (k == 0) begin : g_first
         assign up_valid_w = in_valid;
         assign up_data_w  = in_pl;
      end else begin : g_rest
         assign up_valid_w = v[k-1];
         assign up_data_w  = pl[k-1];
      end
      gray_conv_stage #(
         .WIDTH (WIDTH),
         .STAGES(STAGES),
         .IDX   (k)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .up_valid(up_valid_w),
         .up_data (up_data_w),
         .up_ready(ld[k]),
         .dn_load (ld[k+1]),
         .v_o     (v[k]),
         .pl_o    (pl[k])
      );
   end

   assign ld[STAGES] = out_ready;
   assign in_ready   = rst_n & ld[0];
   assign out_pl     = pl[STAGES-1];
   assign out_valid  = v[STAGES-1];
   assign out_data   = out_pl.partial[WIDTH-1:0];
   assign out_mode   = out_pl.mode;

`ifdef GRAY_CONV_STEP_CHECK_EN
   logic [WIDTH-1:0] hist_d, hist_q;
   logic             hist_vld_d, hist_vld_q;

   // compare each accepted Gray word with the previous one
   always_comb begin
      hist_d     = hist_q;
      hist_vld_d = hist_vld_q;
      in_err     = 1'b0;
      if (in_mode == GRAY_CONV_G2B) begin
         in_err = hist_vld_q && ($countones(in_data ^ hist_q) != 1);
      end
      if (in_valid && in_ready) begin
         if (in_mode == GRAY_CONV_G2B) begin
            hist_d     = in_data;
            hist_vld_d = 1'b1;
         end else begin
            hist_vld_d = 1'b0;
         end
      end
   end

   // history register for the step checker
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_q     <= '0;
         hist_vld_q <= 1'b0;
      end else begin
         hist_q     <= hist_d;
         hist_vld_q <= hist_vld_d;
      end
   end

   assign step_err = out_pl.err;
`else
   assign in_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_code_conv_pipe.sv
// tb_gray_code_conv_pipe: self-checking bench for gray_code_conv_pipe.
// Honours GRAY_CONV_STEP_CHECK_EN when defined.
module tb_gray_code_conv_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   logic       rst_n;
   logic       in_valid, in_ready, in_mode;
   logic [3:0] in_data;
   logic       out_valid, out_ready, out_mode;
   logic [3:0] out_data;
   logic       step_err;
   logic       f_in, f_out;

   logic        s_in_valid [3];
   logic        s_in_ready [3];
   logic        s_in_mode  [3];
   logic [15:0] s_in_data  [3];
   logic        s_out_valid[3];
   logic        s_out_ready[3];
   logic        s_out_mode [3];
   logic [15:0] s_out_data [3];
   logic        s_err      [3];
   int          sst        [3] = '{1, 4, 16};

   gray_code_conv_pipe #(.WIDTH(4), .STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_mode(out_mode)
`ifdef GRAY_CONV_STEP_CHECK_EN
      , .step_err(step_err)
`endif
   );

   gray_code_conv_pipe #(.WIDTH(16), .STAGES(1)) dut_s1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid[0]), .in_ready(s_in_ready[0]),
      .in_data(s_in_data[0]), .in_mode(s_in_mode[0]),
      .out_valid(s_out_valid[0]), .out_ready(s_out_ready[0]),
      .out_data(s_out_data[0]), .out_mode(s_out_mode[0])
`ifdef GRAY_CONV_STEP_CHECK_EN
      , .step_err(s_err[0])
`endif
   );

   gray_code_conv_pipe #(.WIDTH(16), .STAGES(4)) dut_s4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid[1]), .in_ready(s_in_ready[1]),
      .in_data(s_in_data[1]), .in_mode(s_in_mode[1]),
      .out_valid(s_out_valid[1]), .out_ready(s_out_ready[1]),
      .out_data(s_out_data[1]), .out_mode(s_out_mode[1])
`ifdef GRAY_CONV_STEP_CHECK_EN
      , .step_err(s_err[1])
`endif
   );

   gray_code_conv_pipe #(.WIDTH(16), .STAGES(16)) dut_s16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid[2]), .in_ready(s_in_ready[2]),
      .in_data(s_in_data[2]), .in_mode(s_in_mode[2]),
      .out_valid(s_out_valid[2]), .out_ready(s_out_ready[2]),
      .out_data(s_out_data[2]), .out_mode(s_out_mode[2])
`ifdef GRAY_CONV_STEP_CHECK_EN
      , .step_err(s_err[2])
`endif
   );

   // reference: binary bit i is the parity of all Gray bits at or above i
   function automatic logic [63:0] ref_g2b(input logic [63:0] g, input int w);
      logic [63:0] b;
      b = '0;
      for (int s = 0; s < w; s++) b ^= (g >> s);
      return b;
   endfunction

   function automatic logic [63:0] ref_conv(input logic [63:0] d,
                                            input logic m, input int w);
      if (m) return d ^ (d >> 1);
      return ref_g2b(d, w);
   endfunction

   task automatic tick(input logic iv, input logic [3:0] id,
                       input logic im, input logic orr);
      @(negedge clk);
      in_valid  = iv;
      in_data   = id;
      in_mode   = im;
      out_ready = orr;
      #1;
      f_in  = in_valid && in_ready;
      f_out = out_valid && out_ready;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         s_in_valid[j] = 1'b0; s_in_data[j] = '0;
         s_in_mode[j] = 1'b0; s_out_ready[j] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL rst_in_ready got %b want 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0 || out_data !== 4'h0 || out_mode !== 1'b0) begin
         errors++;
         $display("FAIL rst_out got v=%b d=%h m=%b want 0 0 0",
                  out_valid, out_data, out_mode);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_release got rdy=%b v=%b want 1 0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_g2b_table;
      int ni = 0;
      int no = 0;
      int acc[$];
      logic [3:0] gin;
      for (int c = 0; c < 40 && no < 16; c++) begin
         gin = 4'(ni ^ (ni >> 1));
         tick(ni < 16, gin, 1'b0, 1'b1);
         if (f_in) begin
            acc.push_back(cyc);
            ni++;
         end
         if (f_out) begin
            checks++;
            if (out_data !== 4'(no) || out_mode !== 1'b0) begin
               errors++;
               $display("FAIL g2b_table[%0d] got %b/%b want %b/0",
                        no, out_data, out_mode, 4'(no));
            end
            checks++;
            if (cyc - acc[0] != 2) begin
               errors++;
               $display("FAIL g2b_latency got %0d want 2", cyc - acc[0]);
            end
            void'(acc.pop_front());
            no++;
         end
      end
      checks++;
      if (no != 16) begin
         errors++; $display("FAIL g2b_count got %0d want 16", no);
      end
   endtask

   task automatic test_mixed;
      logic [3:0] wd [3] = '{4'b1011, 4'b1000, 4'b0111};
      logic       wm [3] = '{1'b1, 1'b0, 1'b1};
      logic [3:0] ed [3] = '{4'b1110, 4'b1111, 4'b0100};
      int ni = 0;
      int no = 0;
      for (int c = 0; c < 12 && no < 3; c++) begin
         tick(ni < 3, (ni < 3) ? wd[ni] : 4'h0,
              (ni < 3) ? wm[ni] : 1'b0, 1'b1);
         if (c < 3) begin
            checks++;
            if (!f_in) begin
               errors++; $display("FAIL mixed_b2b got 0 want 1 at %0d", c);
            end
         end
         if (f_in) ni++;
         if (f_out) begin
            checks++;
            if (out_data !== ed[no] || out_mode !== wm[no]) begin
               errors++;
               $display("FAIL mixed[%0d] got %b/%b want %b/%b",
                        no, out_data, out_mode, ed[no], wm[no]);
            end
            no++;
         end
      end
      checks++;
      if (no != 3) begin
         errors++; $display("FAIL mixed_count got %0d want 3", no);
      end
   endtask

   task automatic test_backpressure;
      logic [3:0] w [3];
      logic [3:0] hold;
      int ni = 0;
      int no = 0;
      int last = 0;
      for (int i = 0; i < 3; i++) w[i] = 4'($urandom);
      for (int c = 0; c < 6; c++) begin
         tick(ni < 3, (ni < 3) ? w[ni] : 4'h0, 1'b0, 1'b0);
         if (f_in) ni++;
      end
      checks++;
      if (ni != 2) begin
         errors++; $display("FAIL bp_accepted got %0d want 2", ni);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_in_ready got %b want 0", in_ready);
      end
      hold = out_data;
      checks++;
      if (out_valid !== 1'b1 || hold !== 4'(ref_g2b(64'(w[0]), 4))) begin
         errors++;
         $display("FAIL bp_head got v=%b d=%b want 1 %b",
                  out_valid, hold, 4'(ref_g2b(64'(w[0]), 4)));
      end
      for (int c = 0; c < 3; c++) begin
         tick(1'b1, w[2], 1'b0, 1'b0);
         checks++;
         if (f_in || out_data !== hold || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got d=%b in=%b want %b 0",
                     out_data, f_in, hold);
         end
      end
      for (int c = 0; c < 10 && no < 3; c++) begin
         tick(ni < 3, (ni < 3) ? w[ni] : 4'h0, 1'b0, 1'b1);
         if (f_in) ni++;
         if (f_out) begin
            checks++;
            if (out_data !== 4'(ref_g2b(64'(w[no]), 4))) begin
               errors++;
               $display("FAIL bp_drain[%0d] got %b want %b", no,
                        out_data, 4'(ref_g2b(64'(w[no]), 4)));
            end
            if (no > 0) begin
               checks++;
               if (cyc - last != 1) begin
                  errors++;
                  $display("FAIL bp_rate got gap %0d want 1", cyc - last);
               end
            end
            last = cyc;
            no++;
         end
      end
      checks++;
      if (no != 3) begin
         errors++; $display("FAIL bp_count got %0d want 3", no);
      end
   endtask

   task automatic test_reset_mid;
      int ni = 0;
      int leaks = 0;
      for (int c = 0; c < 4; c++) begin
         tick(ni < 2, 4'($urandom), 1'($urandom), 1'b0);
         if (f_in) ni++;
      end
      checks++;
      if (ni != 2) begin
         errors++; $display("FAIL rmid_fill got %0d want 2", ni);
      end
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL rmid_in_ready got %b want 0", in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 4'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rmid_after got v=%b d=%h rdy=%b want 0 0 1",
                  out_valid, out_data, in_ready);
      end
      for (int c = 0; c < 6; c++) begin
         tick(1'b0, 4'h0, 1'b0, 1'b1);
         if (f_out) leaks++;
      end
      checks++;
      if (leaks != 0) begin
         errors++; $display("FAIL rmid_leak got %0d want 0", leaks);
      end
   endtask

   task automatic test_sweep;
      logic [15:0] qd [3][$];
      logic        qm [3][$];
      logic        fi [3];
      logic        fo [3];
      int          t0;
      int          lat [3];
      for (int c = 0; c < 460; c++) begin
         @(negedge clk);
         for (int j = 0; j < 3; j++) begin
            s_in_valid[j]  = (c < 400) && ($urandom_range(0, 3) != 0);
            s_in_data[j]   = 16'($urandom);
            s_in_mode[j]   = 1'($urandom);
            s_out_ready[j] = (c >= 400) || ($urandom_range(0, 3) != 0);
         end
         #1;
         for (int j = 0; j < 3; j++) begin
            fi[j] = s_in_valid[j] && s_in_ready[j];
            fo[j] = s_out_valid[j] && s_out_ready[j];
            if (fi[j]) begin
               qd[j].push_back(16'(ref_conv(64'(s_in_data[j]),
                                            s_in_mode[j], 16)));
               qm[j].push_back(s_in_mode[j]);
            end
            if (fo[j]) begin
               checks++;
               if (qd[j].size() == 0) begin
                  errors++;
                  $display("FAIL sweep_s%0d_extra got %h want none",
                           sst[j], s_out_data[j]);
               end else begin
                  if (s_out_data[j] !== qd[j][0] ||
                      s_out_mode[j] !== qm[j][0]) begin
                     errors++;
                     $display("FAIL sweep_s%0d got %h/%b want %h/%b", sst[j],
                              s_out_data[j], s_out_mode[j], qd[j][0], qm[j][0]);
                  end
                  void'(qd[j].pop_front());
                  void'(qm[j].pop_front());
               end
            end
         end
      end
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (qd[j].size() != 0) begin
            errors++;
            $display("FAIL sweep_s%0d_left got %0d want 0",
                     sst[j], qd[j].size());
         end
      end
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         s_in_valid[j] = 1'b1; s_in_data[j] = 16'hB5A3;
         s_in_mode[j] = 1'b0; s_out_ready[j] = 1'b1; lat[j] = -1;
      end
      t0 = cyc;
      @(negedge clk);
      for (int j = 0; j < 3; j++) s_in_valid[j] = 1'b0;
      for (int c = 0; c < 30; c++) begin
         #1;
         for (int j = 0; j < 3; j++) begin
            if (s_out_valid[j] && lat[j] < 0) begin
               lat[j] = cyc - t0;
               checks++;
               if (s_out_data[j] !== 16'(ref_g2b(64'h0000_0000_0000_B5A3, 16))) begin
                  errors++;
                  $display("FAIL lat_data_s%0d got %h want %h", sst[j],
                           s_out_data[j], 16'(ref_g2b(64'hB5A3, 16)));
               end
            end
         end
         @(negedge clk);
      end
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (lat[j] != sst[j]) begin
            errors++;
            $display("FAIL sweep_lat_s%0d got %0d want %0d",
                     sst[j], lat[j], sst[j]);
         end
      end
   endtask

`ifdef GRAY_CONV_STEP_CHECK_EN
   task automatic test_step;
      logic [3:0] wd [5] = '{4'b0001, 4'b0011, 4'b0000, 4'b0101, 4'b1111};
      logic       wm [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic       eq [$];
      logic [3:0] h = '0;
      logic       hv = 1'b0;
      int ni = 0;
      int no = 0;
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20 && no < 5; c++) begin
         tick(ni < 5, (ni < 5) ? wd[ni] : 4'h0,
              (ni < 5) ? wm[ni] : 1'b0, 1'b1);
         if (f_in) begin
            if (!wm[ni]) begin
               eq.push_back(hv && ($countones(wd[ni] ^ h) != 1));
               h = wd[ni]; hv = 1'b1;
            end else begin
               eq.push_back(1'b0);
               hv = 1'b0;
            end
            ni++;
         end
         if (f_out) begin
            checks++;
            if (step_err !== eq[0]) begin
               errors++;
               $display("FAIL step_err[%0d] got %b want %b", no, step_err, eq[0]);
            end
            void'(eq.pop_front());
            no++;
         end
      end
      checks++;
      if (no != 5) begin
         errors++; $display("FAIL step_count got %0d want 5", no);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_g2b_table();
      test_mixed();
      test_backpressure();
      test_reset_mid();
      test_sweep();
`ifdef GRAY_CONV_STEP_CHECK_EN
      test_step();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
